alu_seq_exec: RTL and testbench

Sequential execution unit on the consumer side of the ALU control interface: it accepts the 5-bit operation code produced by ALUControl together with two 32-bit operands and returns a registered result. Single-cycle operations complete in one cycle. Optional RV32M multiply/divide operations run on an iterative 32-step datapath behind a start/busy/done handshake. It sits in the multicycle/pipelined datapath between the operand registers and the writeback/branch logic.

---
 rtl/alu_seq_exec.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Registered ALU for the ALUControl op codes, with an optional iterative RV32M unit.
// Define MULDIV_EN to compile in the 32-step multiply/divide datapath and its FSM.
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iStart,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oResult,
  output logic             oZero,
  output logic             oBusy,
  output logic             oDone
);
  localparam logic [4:0] OPADD = 5'd0, OPSUB = 5'd1, OPSLL = 5'd2, OPSLT = 5'd3,
                         OPSLTU = 5'd4, OPXOR = 5'd5, OPSRL = 5'd6, OPSRA = 5'd7,
                         OPOR = 5'd8, OPAND = 5'd9, OPLUI = 5'd10, OPGE = 5'd11,
                         OPGEU = 5'd12, OPMUL = 5'd13, OPMULH = 5'd14, OPMULHSU = 5'd15,
                         OPMULHU = 5'd16, OPDIV = 5'd17, OPDIVU = 5'd18, OPREM = 5'd19,
                         OPREMU = 5'd20;

  logic [WIDTH-1:0] quickRes;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, done_q, done_d;

  // Division by zero and signed overflow resolve here so they never enter BUSY.
  always_comb begin
    quickRes = '0;
    case (iControlSignal)
      OPADD:  quickRes = iA + iB;
      OPSUB:  quickRes = iA - iB;
      OPSLL:  quickRes = iA << iB[4:0];
      OPSLT:  quickRes = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(iB)};
      OPSLTU: quickRes = {{(WIDTH-1){1'b0}}, iA < iB};
      OPXOR:  quickRes = iA ^ iB;
      OPSRL:  quickRes = iA >> iB[4:0];
      OPSRA:  quickRes = $signed(iA) >>> iB[4:0];
      OPOR:   quickRes = iA | iB;
      OPAND:  quickRes = iA & iB;
      OPLUI:  quickRes = iB;
      OPGE:   quickRes = {{(WIDTH-1){1'b0}}, $signed(iA) >= $signed(iB)};
      OPGEU:  quickRes = {{(WIDTH-1){1'b0}}, iA >= iB};
`ifdef MULDIV_EN
      OPDIV, OPDIVU: quickRes = (iB == '0) ? '1 : iA;
      OPREM, OPREMU: quickRes = (iB == '0) ? iA : '0;
`endif
      default: quickRes = '0;
    endcase
  end

`ifdef MULDIV_EN
  localparam logic [1:0] ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_FINISH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  step_q, step_d, op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d, opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic        isMulOp, isDivOp, aNeg, bNeg, startIter, qIsDiv;
  logic [31:0] magA, magB, quoFix, remFix, finalRes;
  logic [32:0] mulSum, divShift, divDiff;
  logic [63:0] prodFix;

  always_comb begin
    isMulOp   = iControlSignal inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    isDivOp   = iControlSignal inside {OPDIV, OPDIVU, OPREM, OPREMU};
    aNeg      = iA[31] && (iControlSignal inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM});
    bNeg      = iB[31] && (iControlSignal inside {OPMUL, OPMULH, OPDIV, OPREM});
    magA      = aNeg ? -iA : iA;
    magB      = bNeg ? -iB : iB;
    startIter = isMulOp || (isDivOp && (iB != '0) &&
                !((iControlSignal inside {OPDIV, OPREM}) && iA == 32'h8000_0000 && iB == '1));
  end

  // Shift-add multiply on {hi, lo}; restoring divide keeps the quotient in acc_q[31:0].
  assign mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign divShift = {rem_q, acc_q[31]};
  assign divDiff  = divShift - {1'b0, opnd_q};

  assign qIsDiv  = op_q inside {OPDIV, OPDIVU, OPREM, OPREMU};
  assign prodFix = neg_q ? -acc_q : acc_q;
  assign quoFix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign remFix  = neg_q ? -rem_q : rem_q;

  always_comb begin
    finalRes = '0;
    case (op_q)
      OPMUL:                     finalRes = prodFix[31:0];
      OPMULH, OPMULHSU, OPMULHU: finalRes = prodFix[63:32];
      OPDIV, OPDIVU:             finalRes = quoFix;
      OPREM, OPREMU:             finalRes = remFix;
      default:                   finalRes = '0;
    endcase
  end
`endif

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
`ifdef MULDIV_EN
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart && startIter) begin
          op_d    = iControlSignal;
          neg_d   = (iControlSignal inside {OPREM, OPREMU}) ? aNeg : (aNeg ^ bNeg);
          opnd_d  = isDivOp ? magB : magA;
          acc_d   = {32'd0, isDivOp ? magA : magB};
          rem_d   = '0;
          step_d  = '0;
          state_d = ST_BUSY;
        end else if (iStart) begin
          result_d = quickRes;
          zero_d   = (quickRes == '0);
          done_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (qIsDiv) begin
          acc_d = {acc_q[63:32], acc_q[30:0], ~divDiff[32]};
          rem_d = divDiff[32] ? divShift[31:0] : divDiff[31:0];
        end else begin
          acc_d = {mulSum, acc_q[31:1]};
        end
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        result_d = finalRes;
        zero_d   = (finalRes == '0);
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (iStart) begin
      result_d = quickRes;
      zero_d   = (quickRes == '0);
      done_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef MULDIV_EN
      state_q <= ST_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
`endif
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef MULDIV_EN
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign oResult = result_q;
  assign oZero   = zero_q;
  assign oDone   = done_q;
`ifdef MULDIV_EN
  assign oBusy = (state_q != ST_IDLE);
`else
  assign oBusy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: vector table plus scoreboard, with
// expectations that follow whether MULDIV_EN is defined for the build.
module tb_alu_seq_exec;
   localparam logic [4:0] OPADD = 5'd0, OPSUB = 5'd1, OPSLL = 5'd2, OPSLT = 5'd3,
                          OPSLTU = 5'd4, OPXOR = 5'd5, OPSRL = 5'd6, OPSRA = 5'd7,
                          OPOR = 5'd8, OPAND = 5'd9, OPLUI = 5'd10, OPGE = 5'd11,
                          OPGEU = 5'd12, OPMUL = 5'd13, OPMULH = 5'd14, OPMULHSU = 5'd15,
                          OPMULHU = 5'd16, OPDIV = 5'd17, OPDIVU = 5'd18, OPREM = 5'd19,
                          OPREMU = 5'd20;
`ifdef MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int MDLAT = MD ? 33 : 0;

   logic        clock = 1'b0;
   logic        rstn;
   logic        start;
   logic [4:0]  ctrl;
   logic [31:0] opA, opB, result;
   logic        zero, busy, done;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
      int          doneCycle;
   } sb_t;

   vec_t vecs[$];
   sb_t  expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleCnt = 0;

   alu_seq_exec #(.WIDTH(32)) dut (
      .iCLK(clock), .iRSTn(rstn), .iStart(start), .iControlSignal(ctrl),
      .iA(opA), .iB(opB), .oResult(result), .oZero(zero), .oBusy(busy), .oDone(done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every oDone pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      sb_t e;
      if (rstn && done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", {31'd0, done}, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_result"}, result, e.exp);
            checkOutput({e.name, "_zero"}, {31'd0, zero}, {31'd0, (e.exp == 32'd0)});
            checkOutput({e.name, "_latency"}, cycleCnt, e.doneCycle);
         end
      end
   end

   function automatic vec_t mk(input string n, input logic [4:0] op, input logic [31:0] va,
                               input logic [31:0] vb, input logic [31:0] ve, input int lat);
      vec_t v;
      v.name = n; v.op = op; v.a = va; v.b = vb; v.exp = ve; v.lat = lat;
      return v;
   endfunction

   // Drives one request for a single sampling edge, then scrambles the operands.
   task automatic applyStimulus(input string name, input logic [4:0] op, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] ve, input int lat,
                                input bit track);
      sb_t e;
      start = 1'b1; ctrl = op; opA = va; opB = vb;
      if (track) begin
         e.name = name; e.exp = ve; e.doneCycle = cycleCnt + 1 + lat;
         expQ.push_back(e);
      end
      @(negedge clock); #1;
      start = 1'b0;
      opA = $urandom; opB = $urandom; ctrl = 5'($urandom_range(0, 31));
   endtask

   task automatic waitIdle(input int maxCycles);
      for (int i = 0; i < maxCycles && expQ.size() != 0; i++) begin
         @(negedge clock); #1;
      end
      if (expQ.size() != 0) begin
         checkOutput("timeoutPending", expQ.size(), 32'd0);
         expQ.delete();
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: run did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstn = 1'b0; start = 1'b0; ctrl = OPADD; opA = '0; opB = '0;
      repeat (3) @(negedge clock);
      #1;
      checkOutput("resetResult", result, 32'd0);
      checkOutput("resetZero", {31'd0, zero}, 32'd1);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      rstn = 1'b1;
      @(negedge clock); #1;

      vecs.push_back(mk("add",      OPADD,  32'd3,          32'd4,          32'd7,          0));
      vecs.push_back(mk("addWrap",  OPADD,  32'hFFFFFFFF,   32'd1,          32'd0,          0));
      vecs.push_back(mk("subZero",  OPSUB,  32'd5,          32'd5,          32'd0,          0));
      vecs.push_back(mk("subWrap",  OPSUB,  32'd0,          32'd1,          32'hFFFFFFFF,   0));
      vecs.push_back(mk("sll",      OPSLL,  32'd1,          32'h3F,         32'h80000000,   0));
      vecs.push_back(mk("slt",      OPSLT,  32'hFFFFFFFF,   32'd1,          32'd1,          0));
      vecs.push_back(mk("sltu",     OPSLTU, 32'hFFFFFFFF,   32'd1,          32'd0,          0));
      vecs.push_back(mk("xor",      OPXOR,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   0));
      vecs.push_back(mk("srl",      OPSRL,  32'h80000000,   32'd4,          32'h08000000,   0));
      vecs.push_back(mk("sra",      OPSRA,  32'h80000000,   32'd4,          32'hF8000000,   0));
      vecs.push_back(mk("or",       OPOR,   32'hF0F0F0F0,   32'h0F0F0000,   32'hFFFFF0F0,   0));
      vecs.push_back(mk("and",      OPAND,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   0));
      vecs.push_back(mk("lui",      OPLUI,  32'hDEADBEEF,   32'h12345000,   32'h12345000,   0));
      vecs.push_back(mk("geNeg",    OPGE,   32'hFFFFFFFF,   32'd1,          32'd0,          0));
      vecs.push_back(mk("geEq",     OPGE,   32'd5,          32'd5,          32'd1,          0));
      vecs.push_back(mk("geu",      OPGEU,  32'hFFFFFFFF,   32'd1,          32'd1,          0));
      vecs.push_back(mk("geuLess",  OPGEU,  32'd1,          32'd2,          32'd0,          0));
      vecs.push_back(mk("badOp31",  5'd31,  32'd5,          32'd6,          32'd0,          0));
      vecs.push_back(mk("badOp21",  5'd21,  32'd5,          32'd6,          32'd0,          0));
      vecs.push_back(mk("mul",      OPMUL,  32'd7,          32'd6,          MD ? 32'd42 : 32'd0,         MDLAT));
      vecs.push_back(mk("mulNeg",   OPMUL,  32'hFFFFFFFD,   32'd5,          MD ? 32'hFFFFFFF1 : 32'd0,   MDLAT));
      vecs.push_back(mk("mulh",     OPMULH, 32'hFFFFFFFF,   32'd2,          MD ? 32'hFFFFFFFF : 32'd0,   MDLAT));
      vecs.push_back(mk("mulhMin",  OPMULH, 32'h80000000,   32'h80000000,   MD ? 32'h40000000 : 32'd0,   MDLAT));
      vecs.push_back(mk("mulhu",    OPMULHU, 32'hFFFFFFFF,  32'd2,          MD ? 32'd1 : 32'd0,          MDLAT));
      vecs.push_back(mk("mulhsuA",  OPMULHSU, 32'hFFFFFFFF, 32'd2,          MD ? 32'hFFFFFFFF : 32'd0,   MDLAT));
      vecs.push_back(mk("mulhsuB",  OPMULHSU, 32'd2,        32'hFFFFFFFF,   MD ? 32'd1 : 32'd0,          MDLAT));
      vecs.push_back(mk("div",      OPDIV,  32'hFFFFFFF9,   32'd2,          MD ? 32'hFFFFFFFD : 32'd0,   MDLAT));
      vecs.push_back(mk("rem",      OPREM,  32'hFFFFFFF9,   32'd2,          MD ? 32'hFFFFFFFF : 32'd0,   MDLAT));
      vecs.push_back(mk("divNegB",  OPDIV,  32'd7,          32'hFFFFFFFE,   MD ? 32'hFFFFFFFD : 32'd0,   MDLAT));
      vecs.push_back(mk("remNegB",  OPREM,  32'd7,          32'hFFFFFFFE,   MD ? 32'd1 : 32'd0,          MDLAT));
      vecs.push_back(mk("divu",     OPDIVU, 32'd100,        32'd7,          MD ? 32'd14 : 32'd0,         MDLAT));
      vecs.push_back(mk("remu",     OPREMU, 32'd100,        32'd7,          MD ? 32'd2 : 32'd0,          MDLAT));
      vecs.push_back(mk("divuMax",  OPDIVU, 32'hFFFFFFFF,   32'd1,          MD ? 32'hFFFFFFFF : 32'd0,   MDLAT));
      vecs.push_back(mk("divuBy0",  OPDIVU, 32'd10,         32'd0,          MD ? 32'hFFFFFFFF : 32'd0,   0));
      vecs.push_back(mk("remBy0",   OPREM,  32'd10,         32'd0,          MD ? 32'd10 : 32'd0,         0));
      vecs.push_back(mk("divOvf",   OPDIV,  32'h80000000,   32'hFFFFFFFF,   MD ? 32'h80000000 : 32'd0,   0));
      vecs.push_back(mk("remOvf",   OPREM,  32'h80000000,   32'hFFFFFFFF,   32'd0,                       0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
         waitIdle(vecs[i].lat + 5);
      end

      // Busy flag on a multiply, and its completion when MULDIV_EN is absent.
      applyStimulus("mul3x4", OPMUL, 32'd3, 32'd4, MD ? 32'd12 : 32'd0, MDLAT, 1'b1);
      checkOutput("mulBusyFlag", {31'd0, busy}, {31'd0, MD});
      waitIdle(40);
      checkOutput("mulBusyDrop", {31'd0, busy}, 32'd0);

      // Async reset in the middle of a multiply: no completion may follow.
      applyStimulus("preAdd", OPADD, 32'd3, 32'd4, 32'd7, 0, 1'b1);
      waitIdle(5);
      applyStimulus("mulAbort", OPMUL, 32'd7, 32'd6, 32'd0, 0, !MD);
      repeat (8) @(negedge clock);
      #2;
      checkOutput("busyBeforeReset", {31'd0, busy}, {31'd0, MD});
      rstn = 1'b0;
      #1;
      checkOutput("abortResult", result, 32'd0);
      checkOutput("abortZero", {31'd0, zero}, 32'd1);
      checkOutput("abortBusy", {31'd0, busy}, 32'd0);
      checkOutput("abortDone", {31'd0, done}, 32'd0);
      @(negedge clock); #1;
      rstn = 1'b1;
      repeat (40) @(negedge clock);
      #1;
      checkOutput("postAbortResult", result, 32'd0);
      checkOutput("postAbortBusy", {31'd0, busy}, 32'd0);

      // A start during BUSY is ignored; a new request on the oDone cycle is accepted.
      applyStimulus("divuHold", OPDIVU, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, MDLAT, 1'b1);
`ifdef MULDIV_EN
      repeat (4) @(negedge clock);
      #1;
      start = 1'b1; ctrl = OPADD; opA = 32'd1; opB = 32'd1;
      @(negedge clock); #1;
      start = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clock); #1;
      end
      checkOutput("divuDoneSeen", {31'd0, done}, 32'd1);
      applyStimulus("b2bAdd", OPADD, 32'd1, 32'd2, 32'd3, 0, 1'b1);
`endif
      waitIdle(40);
      checkOutput("finalBusy", {31'd0, busy}, 32'd0);
      checkOutput("finalResult", result, MD ? 32'd3 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
